// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage PC register and instruction-fetch sequencer.
// It chooses between a sequential advance, a hold (stall or memory backpressure)
// and an EX-stage redirect. It drives the inst-SRAM request and the IF/ID and
// ID/EX flush pulses.
// Optional feature macro: PC_CTRL_PERF_EN adds the redirect and bubble
// performance counters. When the macro is undefined, both counter outputs read 0.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | fetching; redirect > stall > advance
// REDIR | one bubble after a redirect, kills the in-flight response
// HALT  | misaligned redirect target, parked until reset
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_jump_taken,
  input  logic [31:0] ex_npc,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        fetch_adef,
  output logic [31:0] redirect_cnt,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        adef;
  logic        adef_nxt;
  logic        misaligned;

  assign misaligned = (ex_npc[1:0] != 2'b00);
  assign if_pc      = pc;
  assign fetch_addr = pc;
  assign fetch_adef = adef;

  // State, PC and sticky fault registers; async reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      adef  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      adef  <= adef_nxt;
    end
  end

  // Next-state, next-PC and handshake/flush outputs.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    adef_nxt   = adef;
    fetch_req  = 1'b0;
    if_valid   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        fetch_req = 1'b1;
        if (ex_valid && ex_jump_taken) begin
          // A redirect wins over stall and backpressure. A misaligned target is
          // still loaded into the PC so that it is visible for debug.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          pc_nxt     = ex_npc;
          if (misaligned) begin
            adef_nxt  = 1'b1;
            state_nxt = HALT;
          end else begin
            state_nxt = REDIR;
          end
        end else if (!stall && fetch_ready) begin
          if_valid = 1'b1;
          pc_nxt   = pc + 32'd4;
        end
      end
      REDIR: begin
        // A response for the old stream may already be in flight; kill it.
        flush_ifid = 1'b1;
        state_nxt  = RUN;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

`ifdef PC_CTRL_PERF_EN
  logic redirect;
  logic bubble;

  assign redirect = (state == RUN) && ex_valid && ex_jump_taken;
  assign bubble   = (state == BOOT) || (state == REDIR);

  // Performance counters; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= 32'h0;
      bubble_cnt   <= 32'h0;
    end else begin
      if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
      if (bubble)   bubble_cnt   <= bubble_cnt + 32'd1;
    end
  end
`else
  assign redirect_cnt = 32'h0;
  assign bubble_cnt   = 32'h0;
`endif

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

- Owns the IF-stage PC register and sequences instruction fetch.
- Each cycle it chooses one of: advance sequentially, hold on stall, or take a redirect produced by the EX-stage next-PC logic.
- It drives the instruction-memory request handshake and produces the IF/ID and ID/EX flush pulses.
- Sits between the hazard unit, the EX-stage NPC/jump_taken outputs and the inst-SRAM port.

## Interface
- RESET_PC, 32'h1C00_0000, PC loaded on reset.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction this cycle.
- ex_jump_taken  in  1  EX instruction redirects control flow.
- ex_npc  in  32  redirect target computed in EX.
- stall  in  1  hazard-unit stall request for IF.
- fetch_ready  in  1  inst memory accepts the request this cycle.
- fetch_req  out  1  inst memory request valid.
- fetch_addr  out  32  request address, always equal to if_pc.
- if_pc  out  32  current IF PC.
- if_valid  out  1  instruction at if_pc is captured into IF/ID at this edge.
- flush_ifid  out  1  kill the IF/ID contents.
- flush_idex  out  1  kill the ID/EX contents.
- fetch_adef  out  1  sticky misaligned-fetch fault.
- redirect_cnt  out  32  redirects taken (see Configuration).
- bubble_cnt  out  32  cycles with fetch_req low while not in HALT (see Configuration).

## Operation
- **State machine:** BOOT, RUN, REDIR, HALT.
- **Reset:** state=BOOT, if_pc=RESET_PC, fetch_adef=0, counters=0. All outputs low except if_pc and fetch_addr, which are RESET_PC.
- **BOOT:**
  - fetch_req=0.
  - Unconditionally goes to RUN at the next edge.
  - Redirect inputs are ignored.
- **Redirect event** = state==RUN & ex_valid & ex_jump_taken.
- **RUN:** fetch_req=1. Priority is redirect > stall > advance.
  - **Redirect, ex_npc[1:0]==0:**
    - flush_ifid=1 and flush_idex=1, combinational in the same cycle.
    - if_pc <= ex_npc; next state REDIR.
    - Overrides stall and fetch_ready.
  - **Redirect, ex_npc[1:0]!=0:**
    - Both flushes asserted.
    - if_pc <= ex_npc, held for debug.
    - fetch_adef <= 1; next state HALT.
  - **Stall, no redirect:**
    - if_pc held; fetch_req stays 1 (re-request the same address); if_valid=0.
  - **Otherwise, fetch_ready=1:** if_valid=1 and if_pc <= if_pc + 4. The add wraps mod 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.
  - **Otherwise, fetch_ready=0:** if_pc held, if_valid=0.
- **REDIR:** one bubble cycle.
  - fetch_req=0, if_valid=0.
  - flush_ifid=1 again to kill a response already in flight; flush_idex=0.
  - Redirect inputs are ignored; the EX stage holds a flushed bubble.
  - Next state RUN.
- **HALT:**
  - fetch_req=0, if_valid=0, flushes 0.
  - Exits only via rst_n.
- **Flush outputs** are 0 in BOOT, HALT and while rst_n is low.
- **Reset mid-operation:** asserting rst_n low in any state forces the reset values immediately, without waiting for a clock edge. Any pending redirect is discarded.

## Timing
- Reset release: BOOT occupies the first edge after rst_n rises; fetch_req=1 for RESET_PC from the following cycle.
- Redirect sampled in cycle N:
  - flushes high in N;
  - if_pc=ex_npc and REDIR in N+1;
  - fetch_req=1 at the target in N+2.
- Redirect penalty: 2 cycles of lost fetch on top of the flushed instructions.
- Sequential fetch throughput: one PC per cycle while fetch_ready=1 and stall=0.
- fetch_addr and if_pc change only on a clock edge; they are stable while fetch_ready=0.

## Configuration
- Macro: PC_CTRL_PERF_EN.
- **Defined:**
  - redirect_cnt increments on each redirect event, including misaligned ones.
  - bubble_cnt increments each cycle in BOOT or REDIR.
  - Both wrap at 2^32 and reset to 0.
- **Undefined:** both outputs tied to 32'h0 and no counter flops are synthesized.

## Test plan
- **Reset/boot:** release rst_n with fetch_ready=1, no stall.
  - Required: fetch_req=0 for 1 cycle.
  - Then fetch_addr sequence 1C000000, 1C000004, 1C000008, with if_valid=1 each cycle.
- **Stall and backpressure:**
  - At if_pc=1C000008, hold stall=1 for 3 cycles → if_pc held at 1C000008 with fetch_req=1 and if_valid=0.
  - Then hold fetch_ready=0 for 2 cycles → same result.
  - Then the PC resumes at 1C00000C.
- **Redirect:** ex_valid=ex_jump_taken=1, ex_npc=1C000100, with stall=1 in the same cycle.
  - Required: flush_ifid and flush_idex high in that cycle.
  - Next cycle: REDIR, flush_ifid=1, fetch_req=0.
  - Following cycle: fetch_addr=1C000100; redirect_cnt=1 and bubble_cnt=2 with PC_CTRL_PERF_EN.
- **Misaligned target:** ex_npc=1C000102.
  - Required: flushes high; fetch_adef=1 from the next cycle; fetch_req stays 0 indefinitely until rst_n.
- **Wrap:** redirect to FFFFFFFC, then 2 accepted fetches → fetch_addr FFFFFFFC, then 00000000.
- **Async reset mid-REDIR:**
  - Drop rst_n between edges → if_pc=1C000000 and flushes 0 immediately.
  - BOOT sequence repeats after release.
